// File: rtl/iitb_risc_pkg.sv
// Shared IITB-RISC decode definitions.
// Holds the LM/SM opcodes, the default instruction width, the decode-stage
// sequencer state encoding and the architectural register-index type.
// No ports; imported by the sequencer, its interface and its sub-module.
package iitb_risc_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic {
        IDLE,
        SEQ
    } lmsm_state_t;

    typedef logic [2:0] reg_idx_t;

    // True for the two multi-register memory opcodes
    function automatic logic is_lmsm_op(input logic [3:0] op);
        return (op == OP_LM) || (op == OP_SM);
    endfunction

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Bus between the IF/ID register / hazard unit and the LM/SM sequencer.
// master : upstream side (drives in_*, stall_in, flush; observes outputs)
// slave  : the sequencer (consumes in_*, stall_in, flush; drives hold_fetch
//          and the out_* ID-stage outputs)
interface lmsm_sequencer_if;
    import iitb_risc_pkg::*;

    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic [INSTR_W-1:0] in_pc;
    logic               stall_in;
    logic               flush;
    logic               hold_fetch;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [INSTR_W-1:0] out_pc;
    logic               out_is_lmsm;
    reg_idx_t           out_reg;
    reg_idx_t           out_offset;
    logic               out_last;

    modport master (
        output in_valid, in_instr, in_pc, stall_in, flush,
        input  hold_fetch, out_valid, out_instr, out_pc, out_is_lmsm,
               out_reg, out_offset, out_last
    );

    modport slave (
        input  in_valid, in_instr, in_pc, stall_in, flush,
        output hold_fetch, out_valid, out_instr, out_pc, out_is_lmsm,
               out_reg, out_offset, out_last
    );

endinterface

// File: rtl/lmsm_prio_enc.sv
// Lowest-register priority encoder for LM/SM register lists.
// The list is stored MSB-first: mask[NREGS-1-i] selects Ri, so R0 lives in
// the top bit.
// Ports: mask   (in)  register list
//        idx    (out) lowest selected register index
//        onehot (out) list bit belonging to idx (zero when nothing found)
//        found  (out) list is non-zero
module lmsm_prio_enc
    import iitb_risc_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic [NREGS-1:0] mask,
    output reg_idx_t         idx,
    output logic [NREGS-1:0] onehot,
    output logic             found
);

    // Scan from the highest register down so the lowest hit is written last
    always_comb begin
        idx    = '0;
        onehot = '0;
        found  = 1'b0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask[NREGS-1-i]) begin
                idx                = reg_idx_t'(i);
                onehot             = '0;
                onehot[NREGS-1-i]  = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// Decode-stage front end: ID pipeline register that expands LM/SM into one
// single-register micro-op per selected register, holding fetch meanwhile.
// Ports: clk, reset (sync, active-high), bus (lmsm_sequencer_if.slave):
//   in_valid/in_instr/in_pc from IF/ID, stall_in, flush,
//   hold_fetch, out_valid/out_instr/out_pc, out_is_lmsm, out_reg,
//   out_offset, out_last.
// Configuration: IITB_LMSM_EN enables the expansion; without it the block
// is a plain ID register and hold_fetch is tied low.
module lmsm_sequencer #(
    parameter int INSTR_W = 16,
    parameter int NREGS   = 8
) (
    input  logic             clk,
    input  logic             reset,
    lmsm_sequencer_if.slave  bus
);
    import iitb_risc_pkg::*;

    localparam int REG_W = $clog2(NREGS);

    logic               out_valid_q, out_valid_n;
    logic [INSTR_W-1:0] out_instr_q, out_instr_n;
    logic [INSTR_W-1:0] out_pc_q,    out_pc_n;
    logic               out_is_q,    out_is_n;
    logic [REG_W-1:0]   out_reg_q,   out_reg_n;
    logic [REG_W-1:0]   out_off_q,   out_off_n;
    logic               out_last_q,  out_last_n;

`ifdef IITB_LMSM_EN
    lmsm_state_t      state, state_n;
    logic [NREGS-1:0] rem, rem_n;
    logic [REG_W-1:0] cnt, cnt_n;

    logic [NREGS-1:0] enc_mask, enc_onehot, rem_left;
    reg_idx_t         enc_idx;
    logic             enc_found;
    logic             in_is_lmsm;

    // One encoder serves both the incoming list (IDLE) and the remainder (SEQ)
    assign enc_mask   = (state == SEQ) ? rem : bus.in_instr[NREGS-1:0];
    assign rem_left   = enc_mask & ~enc_onehot;
    assign in_is_lmsm = is_lmsm_op(bus.in_instr[INSTR_W-1 -: 4]);

    lmsm_prio_enc #(.NREGS(NREGS)) u_enc (
        .mask   (enc_mask),
        .idx    (enc_idx),
        .onehot (enc_onehot),
        .found  (enc_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        rem_n       = rem;
        cnt_n       = cnt;
        out_valid_n = out_valid_q;
        out_instr_n = out_instr_q;
        out_pc_n    = out_pc_q;
        out_is_n    = out_is_q;
        out_reg_n   = out_reg_q;
        out_off_n   = out_off_q;
        out_last_n  = out_last_q;
        if (bus.flush) begin
            out_valid_n = 1'b0;
            state_n     = IDLE;
            rem_n       = '0;
            cnt_n       = '0;
        end else if (!bus.stall_in) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        out_instr_n = bus.in_instr;
                        out_pc_n    = bus.in_pc;
                        if (in_is_lmsm) begin
                            // An empty list leaves a bubble and nothing queued
                            out_valid_n = enc_found;
                            out_is_n    = 1'b1;
                            out_reg_n   = enc_idx;
                            out_off_n   = '0;
                            out_last_n  = (rem_left == '0);
                            rem_n       = rem_left;
                            cnt_n       = enc_found ? REG_W'(1) : '0;
                            state_n     = (rem_left != '0) ? SEQ : IDLE;
                        end else begin
                            out_valid_n = 1'b1;
                            out_is_n    = 1'b0;
                            out_reg_n   = '0;
                            out_off_n   = '0;
                            out_last_n  = 1'b1;
                        end
                    end else begin
                        out_valid_n = 1'b0;
                    end
                end
                SEQ: begin
                    out_valid_n = 1'b1;
                    out_is_n    = 1'b1;
                    out_reg_n   = enc_idx;
                    out_off_n   = cnt;
                    out_last_n  = (rem_left == '0);
                    rem_n       = rem_left;
                    cnt_n       = cnt + REG_W'(1);
                    state_n     = (rem_left == '0) ? IDLE : SEQ;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.hold_fetch = (state == SEQ);
`else
    always_comb begin
        out_valid_n = out_valid_q;
        out_instr_n = out_instr_q;
        out_pc_n    = out_pc_q;
        out_is_n    = out_is_q;
        out_reg_n   = out_reg_q;
        out_off_n   = out_off_q;
        out_last_n  = out_last_q;
        if (bus.flush) begin
            out_valid_n = 1'b0;
        end else if (!bus.stall_in) begin
            out_valid_n = bus.in_valid;
            if (bus.in_valid) begin
                out_instr_n = bus.in_instr;
                out_pc_n    = bus.in_pc;
                out_is_n    = 1'b0;
                out_reg_n   = '0;
                out_off_n   = '0;
                out_last_n  = 1'b1;
            end
        end
    end

    assign bus.hold_fetch = 1'b0;
`endif

    // ID register boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_is_q    <= 1'b0;
            out_reg_q   <= '0;
            out_off_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_n;
            out_instr_q <= out_instr_n;
            out_pc_q    <= out_pc_n;
            out_is_q    <= out_is_n;
            out_reg_q   <= out_reg_n;
            out_off_q   <= out_off_n;
            out_last_q  <= out_last_n;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_is_lmsm = out_is_q;
    assign bus.out_reg     = out_reg_q;
    assign bus.out_offset  = out_off_q;
    assign bus.out_last    = out_last_q;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Testbench for lmsm_sequencer: per-cycle directed vector table plus
// hand-written reset sequences. Covers both IITB_LMSM_EN builds.
module tb_lmsm_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lmsm_sequencer_if bus();

    lmsm_sequencer #(.INSTR_W(16), .NREGS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Observation word: {valid, is_lmsm, last, hold, reg[2:0], off[2:0], instr, pc}
    typedef logic [41:0] obs_t;
    localparam obs_t M_ALL   = '1;
    localparam obs_t M_NOREG = ~(obs_t'(7) << 35);
    localparam obs_t M_VH    = (obs_t'(1) << 41) | (obs_t'(1) << 38);

    localparam logic [15:0] ADD = 16'h0050;
    localparam logic [15:0] I1  = 16'h1234;
    localparam logic [15:0] I2  = 16'h2345;

    typedef struct {
        string       name;
        logic        v;
        logic [15:0] instr;
        logic [15:0] pc;
        logic        st;
        logic        fl;
        obs_t        exp;
        obs_t        mask;
    } vec_t;

    vec_t vecs[$];

    function automatic obs_t pk(logic v, logic is, logic last, logic hold,
                                logic [2:0] r, logic [2:0] o,
                                logic [15:0] i, logic [15:0] p);
        return {v, is, last, hold, r, o, i, p};
    endfunction

    // Ordinary instruction expected on the output
    function automatic vec_t pt(string n, logic v, logic [15:0] i, logic [15:0] p,
                                logic st, logic fl, logic [15:0] ei, logic [15:0] ep);
        return '{n, v, i, p, st, fl, pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, ei, ep), M_NOREG};
    endfunction

    // LM/SM micro-op expected on the output
    function automatic vec_t uop(string n, logic [15:0] i, logic [15:0] p, logic st,
                                 logic [2:0] r, logic [2:0] o, logic last, logic hold,
                                 logic [15:0] ei, logic [15:0] ep);
        return '{n, 1'b1, i, p, st, 1'b0, pk(1'b1, 1'b1, last, hold, r, o, ei, ep), M_ALL};
    endfunction

    // Only valid and hold_fetch matter
    function automatic vec_t vh(string n, logic v, logic [15:0] i, logic [15:0] p,
                                logic st, logic fl, logic ev, logic eh);
        return '{n, v, i, p, st, fl, pk(ev, 1'b0, 1'b0, eh, 3'd0, 3'd0, 16'h0, 16'h0), M_VH};
    endfunction

    task automatic drive(logic v, logic [15:0] i, logic [15:0] p, logic st, logic fl);
        bus.in_valid = v;
        bus.in_instr = i;
        bus.in_pc    = p;
        bus.stall_in = st;
        bus.flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, obs_t exp, obs_t m);
        obs_t act;
        act = pk(bus.out_valid, bus.out_is_lmsm, bus.out_last, bus.hold_fetch,
                 bus.out_reg, bus.out_offset, bus.out_instr, bus.out_pc);
        checks++;
        if ((act & m) !== (exp & m)) begin
            failures++;
            $display("FAIL %s: got %h required %h (mask %h)", name, act & m, exp & m, m);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        chk("reset_state", '0, M_ALL);
        reset = 1'b0;

`ifdef IITB_LMSM_EN
        vecs.push_back(pt ("add",        1'b1, ADD, 16'h0010, 1'b0, 1'b0, ADD, 16'h0010));
        vecs.push_back(uop("lm_a1_r0",   16'h60A1, 16'h0012, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 16'h60A1, 16'h0012));
        vecs.push_back(uop("lm_a1_r2",   I1, 16'h0014, 1'b0, 3'd2, 3'd1, 1'b0, 1'b1, 16'h60A1, 16'h0012));
        vecs.push_back(uop("lm_a1_r7",   I1, 16'h0014, 1'b0, 3'd7, 3'd2, 1'b1, 1'b0, 16'h60A1, 16'h0012));
        vecs.push_back(pt ("after_lm",   1'b1, I1, 16'h0014, 1'b0, 1'b0, I1, 16'h0014));
        vecs.push_back(uop("sm_r0",      16'h70FF, 16'h0016, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 16'h70FF, 16'h0016));
        vecs.push_back(uop("sm_r1",      I2, 16'h0018, 1'b0, 3'd1, 3'd1, 1'b0, 1'b1, 16'h70FF, 16'h0016));
        vecs.push_back(uop("sm_r2",      I2, 16'h0018, 1'b0, 3'd2, 3'd2, 1'b0, 1'b1, 16'h70FF, 16'h0016));
        vecs.push_back(uop("sm_stall1",  I2, 16'h0018, 1'b1, 3'd2, 3'd2, 1'b0, 1'b1, 16'h70FF, 16'h0016));
        vecs.push_back(uop("sm_stall2",  I2, 16'h0018, 1'b1, 3'd2, 3'd2, 1'b0, 1'b1, 16'h70FF, 16'h0016));
        vecs.push_back(uop("sm_r3",      I2, 16'h0018, 1'b0, 3'd3, 3'd3, 1'b0, 1'b1, 16'h70FF, 16'h0016));
        vecs.push_back(uop("sm_r4",      I2, 16'h0018, 1'b0, 3'd4, 3'd4, 1'b0, 1'b1, 16'h70FF, 16'h0016));
        vecs.push_back(uop("sm_r5",      I2, 16'h0018, 1'b0, 3'd5, 3'd5, 1'b0, 1'b1, 16'h70FF, 16'h0016));
        vecs.push_back(uop("sm_r6",      I2, 16'h0018, 1'b0, 3'd6, 3'd6, 1'b0, 1'b1, 16'h70FF, 16'h0016));
        vecs.push_back(uop("sm_r7",      I2, 16'h0018, 1'b0, 3'd7, 3'd7, 1'b1, 1'b0, 16'h70FF, 16'h0016));
        vecs.push_back(pt ("after_sm",   1'b1, I2, 16'h0018, 1'b0, 1'b0, I2, 16'h0018));
        vecs.push_back(vh ("lm_empty",   1'b1, 16'h6000, 16'h001A, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(pt ("after_empty",1'b1, I1, 16'h001C, 1'b0, 1'b0, I1, 16'h001C));
        vecs.push_back(uop("lm_f0_r0",   16'h60F0, 16'h001E, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 16'h60F0, 16'h001E));
        vecs.push_back(uop("lm_f0_r1",   ADD, 16'h0020, 1'b0, 3'd1, 3'd1, 1'b0, 1'b1, 16'h60F0, 16'h001E));
        vecs.push_back(vh ("flush_seq",  1'b1, ADD, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(pt ("after_flush",1'b1, ADD, 16'h0020, 1'b0, 1'b0, ADD, 16'h0020));
        vecs.push_back(vh ("flush_stall",1'b1, I2, 16'h0022, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(vh ("stall_bubble",1'b1, I2, 16'h0022, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(vh ("no_valid",   1'b0, I2, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(uop("lm_r7_only", 16'h6001, 16'h0024, 1'b0, 3'd7, 3'd0, 1'b1, 1'b0, 16'h6001, 16'h0024));
        vecs.push_back(pt ("after_r7",   1'b1, ADD, 16'h0026, 1'b0, 1'b0, ADD, 16'h0026));
`else
        vecs.push_back(pt ("add",        1'b1, ADD, 16'h0010, 1'b0, 1'b0, ADD, 16'h0010));
        vecs.push_back(pt ("lm_pass",    1'b1, 16'h60A1, 16'h0012, 1'b0, 1'b0, 16'h60A1, 16'h0012));
        vecs.push_back(pt ("after_lm",   1'b1, I1, 16'h0014, 1'b0, 1'b0, I1, 16'h0014));
        vecs.push_back(pt ("sm_pass",    1'b1, 16'h70FF, 16'h0016, 1'b0, 1'b0, 16'h70FF, 16'h0016));
        vecs.push_back(pt ("stall_hold", 1'b1, I2, 16'h0018, 1'b1, 1'b0, 16'h70FF, 16'h0016));
        vecs.push_back(pt ("after_stall",1'b1, I2, 16'h0018, 1'b0, 1'b0, I2, 16'h0018));
        vecs.push_back(pt ("lm_empty",   1'b1, 16'h6000, 16'h001A, 1'b0, 1'b0, 16'h6000, 16'h001A));
        vecs.push_back(vh ("flush",      1'b1, I1, 16'h001C, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(pt ("after_flush",1'b1, I1, 16'h001C, 1'b0, 1'b0, I1, 16'h001C));
        vecs.push_back(vh ("flush_stall",1'b1, I2, 16'h0022, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(vh ("stall_bubble",1'b1, I2, 16'h0022, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(vh ("no_valid",   1'b0, I2, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(pt ("lm_single",  1'b1, 16'h6001, 16'h0024, 1'b0, 1'b0, 16'h6001, 16'h0024));
`endif

        foreach (vecs[k]) begin
            drive(vecs[k].v, vecs[k].instr, vecs[k].pc, vecs[k].st, vecs[k].fl);
            tick();
            chk(vecs[k].name, vecs[k].exp, vecs[k].mask);
        end

        // Reset together with stall while an LM is in flight
        drive(1'b1, 16'h60FF, 16'h0030, 1'b0, 1'b0);
        tick();
`ifdef IITB_LMSM_EN
        chk("pre_reset_seq", pk(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 16'h60FF, 16'h0030), M_ALL);
        drive(1'b1, I1, 16'h0032, 1'b0, 1'b0);
        tick();
        chk("pre_reset_seq2", pk(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 3'd1, 16'h60FF, 16'h0030), M_ALL);
`else
        chk("pre_reset_pass", pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 16'h60FF, 16'h0030), M_NOREG);
`endif
        reset = 1'b1;
        drive(1'b1, I1, 16'h0032, 1'b1, 1'b0);
        tick();
        chk("reset_in_seq", '0, M_ALL);
        reset = 1'b0;
        drive(1'b1, ADD, 16'h0034, 1'b0, 1'b0);
        tick();
        chk("after_reset", pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, ADD, 16'h0034), M_NOREG);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Decode-stage front end of the pipelined IITB-RISC datapath (`datapath_proc`), sitting between the IF/ID register and register read. It is the ID pipeline register for ordinary instructions. It expands each LM (load multiple) or SM (store multiple) instruction into one micro-op per selected register, and holds fetch while the expansion runs. Downstream stages see one single-register load/store per cycle, each carrying its address offset.

## Interface
Parameters:
- `INSTR_W`, 16, instruction and PC width
- `NREGS`, 8, architectural registers; register-list width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  IF/ID holds a valid instruction
- `in_instr`  in  16  instruction from IF/ID
- `in_pc`  in  16  PC of `in_instr`
- `stall_in`  in  1  hazard-unit stall; hold all state
- `flush`  in  1  branch/jump misprediction flush
- `hold_fetch`  out  1  PC and IF/ID must not advance
- `out_valid`  out  1  ID output valid
- `out_instr`  out  16  original instruction; repeated for every micro-op
- `out_pc`  out  16  PC of that instruction
- `out_is_lmsm`  out  1  output is an LM/SM micro-op
- `out_reg`  out  3  register for this micro-op
- `out_offset`  out  3  word offset from RA (0..7)
- `out_last`  out  1  final micro-op of an instruction; 1 for non-LM/SM instructions

## Operation
- States:
  - IDLE: pass-through and accept.
  - SEQ: draining the remaining mask `rem[7:0]`; offset counter `cnt[2:0]`.
- LM/SM is decoded from `in_instr[15:12]`. The register list is `in_instr[7:0]`. Bit `imm[7-i]` selects Ri. Registers are processed in ascending index order, R0 first.
- IDLE, `in_valid`=1, not LM/SM:
  - Register the instruction with `out_valid`=1, `out_is_lmsm`=0, `out_last`=1, `out_offset`=0.
- IDLE, LM/SM, list non-zero:
  - Emit micro-op 0: lowest selected register, offset 0.
  - `rem` = list minus that bit; `cnt`=1.
  - If `rem`≠0, go to SEQ.
  - If only one bit was set, set `out_last`=1 and stay in IDLE.
- IDLE, LM/SM, list zero: acts as a NOP. Set `out_valid`=0 for one cycle; no hold.
- SEQ:
  - Each non-stalled cycle, emit the lowest register in `rem` with `out_offset`=`cnt`, clear that bit, and increment `cnt`.
  - When `rem` becomes 0: `out_last`=1, go to IDLE.
  - `in_valid`/`in_instr` are ignored in SEQ.
- `hold_fetch` = (state==SEQ), driven combinationally from the state register.
- Priority: `reset` > `flush` > `stall_in` > normal operation.
  - `flush` (and `reset`): `out_valid`←0, state←IDLE, `rem`←0, `cnt`←0. Flush in mid-sequence abandons the remaining micro-ops.
  - `stall_in`=1 without flush: all registers hold, outputs unchanged, `hold_fetch` unchanged.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_is_lmsm`=0, `out_reg`=0, `out_offset`=0, `out_last`=0, `hold_fetch`=0. State is IDLE.
- Latency is 1 cycle, input to registered output, for all instructions.
- LM/SM with k set bits (1≤k≤8):
  - Accepted at cycle t.
  - Micro-ops appear at cycles t+1..t+k.
  - `hold_fetch` is high during cycles t+1..t+k-1.
  - The next instruction is accepted at t+k and appears at t+k+1, with no bubble.
- Stall cycles stretch the sequence one-for-one. Offsets and registers never skip or repeat.
- A full list of 0xFF gives 8 micro-ops with offsets 0..7. `cnt` never wraps within an instruction.

## Configuration
- `IITB_LMSM_EN`
  - Defined: expansion as above.
  - Undefined: the block is a plain ID register.
    - LM/SM pass through as single outputs with `out_is_lmsm`=0, `out_last`=1, `out_offset`=0.
    - `hold_fetch` is tied 0.
    - SEQ logic is not compiled.

## Structure
- Shared package `iitb_risc_pkg` holds:
  - `OP_LM`=4'b0110 and `OP_SM`=4'b0111
  - `INSTR_W`
  - a state enum (IDLE, SEQ)
  - a register-index typedef (3 bits)
- Sub-module `lmsm_prio_enc`: combinational 8-bit mask → lowest register index plus a `found` flag, honouring the `imm[7-i]`↔Ri mapping.

## Test plan
- ADD at PC 0x0010, no stall → next cycle `out_valid`=1, `out_instr`=ADD, `out_last`=1, `hold_fetch`=0.
- LM, list 8'b1010_0001 → three cycles with R0/off0, R2/off1, R7/off2. `out_last` is high on R7 only. `hold_fetch` is high for 2 cycles. The following instruction appears on the 4th cycle.
- SM, list 8'hFF, with `stall_in` high for 2 cycles after the 3rd micro-op → R0..R7 with offsets 0..7. Outputs are frozen during the stall. There are no duplicates.
- LM, list 8'h00 → one cycle with `out_valid`=0, `hold_fetch` never asserted, next instruction accepted the following cycle.
- LM, list 8'hF0, with `flush` asserted after the 2nd micro-op → next cycle `out_valid`=0, state IDLE, `hold_fetch`=0.
- `reset` asserted in SEQ together with `stall_in` → all outputs go to reset values on the next edge.
